// File: rtl/spi_adc_reader_pkg.sv
// Shared types and defaults for the SPI ADC front end (state enum, widths, counter sizing helper).
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD
  } adc_state_t;

  localparam int ADC_SAMPLE_SIZE = 12;
  localparam int ADC_FRAME_BITS  = 16;
  localparam int ADC_CLK_DIV     = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_adc_reader_sclk_gen.sv
// SCLK generator: divides clk into low/high half-periods while run is high, flags
// the capture edge (rise_tick) and the end of each bit (bit_done).
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int clk_div = ADC_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_tick,
  output logic bit_done
);

  localparam int DW = cnt_w(clk_div);

  logic [DW-1:0] div_cnt;
  logic          half_end;

  assign half_end  = run && (div_cnt == DW'(clk_div - 1));
  assign rise_tick = half_end && !sclk;
  assign bit_done  = half_end && sclk;

  // Divider is held clear outside SHIFT so every frame starts on a fresh low half.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/spi_adc_reader.sv
// Free-running SPI mode-0 ADC reader: one frame per conversion, last sample_size bits kept.
// Build option ADC_OFFSET_BINARY_EN: invert the sample MSB (offset-binary to two's complement).
module spi_adc_reader
  import adc_pkg::*;
#(
  parameter int sample_size = ADC_SAMPLE_SIZE,
  parameter int frame_bits  = ADC_FRAME_BITS,
  parameter int clk_div     = ADC_CLK_DIV
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   adc_miso,
  output logic                   adc_cs_n,
  output logic                   adc_sclk,
  output logic [sample_size-1:0] sample_out,
  output logic                   sample_valid,
  output logic                   busy
);

  localparam int DW = cnt_w(clk_div);
  localparam int BW = cnt_w(frame_bits);

  if (frame_bits < sample_size) begin : g_bad_frame
    $error("spi_adc_reader: frame_bits must be >= sample_size");
  end
  if (clk_div < 1) begin : g_bad_div
    $error("spi_adc_reader: clk_div must be >= 1");
  end

  adc_state_t             state, next_state;
  logic [DW-1:0]          wait_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [sample_size-1:0] shreg, sample_bits;
  logic                   rise_tick, bit_done, wait_end, last_bit, hold_done;

  adc_sclk_gen #(.clk_div(clk_div)) u_sclk (
    .clk       (clk),
    .rst       (rst),
    .run       (state == SHIFT),
    .sclk      (adc_sclk),
    .rise_tick (rise_tick),
    .bit_done  (bit_done)
  );

  assign wait_end  = (wait_cnt == DW'(clk_div - 1));
  assign last_bit  = bit_done && (bit_cnt == BW'(frame_bits - 1));
  assign hold_done = (state == CS_HOLD) && wait_end;

`ifdef ADC_OFFSET_BINARY_EN
  assign sample_bits = shreg ^ {1'b1, {(sample_size-1){1'b0}}};
`else
  assign sample_bits = shreg;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (enable)   next_state = CS_SETUP;
      CS_SETUP: if (wait_end) next_state = SHIFT;
      SHIFT:    if (last_bit) next_state = CS_HOLD;
      CS_HOLD:  if (wait_end) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if ((state == CS_SETUP || state == CS_HOLD) && !wait_end) wait_cnt <= wait_cnt + DW'(1);
      else                                                       wait_cnt <= '0;
      if (state != SHIFT) bit_cnt <= '0;
      else if (bit_done)  bit_cnt <= bit_cnt + BW'(1);
    end
  end

  // Only sample_size bits are kept; leading frame bits fall off the top.
  always_ff @(posedge clk) begin
    if (rst)            shreg <= '0;
    else if (rise_tick) shreg <= (shreg << 1) | sample_size'(adc_miso);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adc_cs_n     <= 1'b1;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
    end else begin
      adc_cs_n     <= !(next_state == CS_SETUP || next_state == SHIFT);
      busy         <= (next_state != IDLE);
      sample_valid <= hold_done;
      if (hold_done) sample_out <= sample_bits;
    end
  end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Scoreboard bench: a behavioural ADC drives frames, expected samples are queued at CS fall
// and a monitor checks value and arrival cycle on every sample_valid.
module tb_spi_adc_reader;

  typedef struct {
    logic [11:0] val;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en     [2];
  logic        miso   [2];
  logic        cs_n   [2];
  logic        sclk   [2];
  logic [11:0] sout   [2];
  logic        valid  [2];
  logic        busy   [2];

  int checks = 0, failures = 0, cyc = 0;
  int fbits [2] = '{16, 12};
  int flen  [2] = '{136, 26};

  exp_t        exq0[$], exq1[$];
  int          vt0[$], vt1[$];
  logic [15:0] fw0[$];

  logic [15:0] word  [2];
  int          idx   [2];
  int          rises [2];
  bit          active[2] = '{1'b0, 1'b0};
  logic        pcs   [2] = '{1'b1, 1'b1};
  logic        psclk [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_adc_reader dut0 (
    .clk(clk), .rst(rst), .enable(en[0]), .adc_miso(miso[0]), .adc_cs_n(cs_n[0]),
    .adc_sclk(sclk[0]), .sample_out(sout[0]), .sample_valid(valid[0]), .busy(busy[0])
  );

  spi_adc_reader #(.sample_size(12), .frame_bits(12), .clk_div(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en[1]), .adc_miso(miso[1]), .adc_cs_n(cs_n[1]),
    .adc_sclk(sclk[1]), .sample_out(sout[1]), .sample_valid(valid[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] expected_sample(input logic [15:0] w);
    logic [11:0] s;
    s = 12'(w % 4096);
`ifdef ADC_OFFSET_BINARY_EN
    s = s ^ 12'h800;
`endif
    return s;
  endfunction

  function automatic int nstrobes(input int i);
    return (i == 0) ? vt0.size() : vt1.size();
  endfunction

  function automatic int vtime(input int i, input int k);
    if (i == 0) return (k < vt0.size()) ? vt0[k] : -1;
    return (k < vt1.size()) ? vt1[k] : -1;
  endfunction

  // ADC model plus scoreboard monitor, both evaluated on the falling clock edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        active[i] = 1'b0;
        if (i == 0) exq0.delete(); else exq1.delete();
      end else begin
        if (pcs[i] === 1'b1 && cs_n[i] === 1'b0) begin
          exp_t e;
          word[i]   = (i == 0 && fw0.size() > 0) ? fw0.pop_front() : 16'($urandom);
          idx[i]    = fbits[i] - 1;
          rises[i]  = 0;
          active[i] = 1'b1;
          miso[i]   = word[i][idx[i]];
          e.val     = expected_sample(word[i]);
          e.due     = cyc + flen[i];
          if (i == 0) exq0.push_back(e); else exq1.push_back(e);
          chk($sformatf("busy_at_cs_fall[%0d]", i), int'(busy[i]), 1);
        end else if (pcs[i] === 1'b0 && cs_n[i] === 1'b1 && active[i]) begin
          chk($sformatf("sclk_rises_per_frame[%0d]", i), rises[i], fbits[i]);
          active[i] = 1'b0;
        end
        if (psclk[i] === 1'b0 && sclk[i] === 1'b1) rises[i]++;
        if (psclk[i] === 1'b1 && sclk[i] === 1'b0 && active[i] && idx[i] > 0) begin
          idx[i]--;
          miso[i] = word[i][idx[i]];
        end
        if (valid[i] === 1'b1) begin
          if (i == 0) vt0.push_back(cyc); else vt1.push_back(cyc);
          if ((i == 0 ? exq0.size() : exq1.size()) == 0) begin
            chk($sformatf("unexpected_strobe[%0d]", i), 1, 0);
          end else begin
            exp_t e;
            e = (i == 0) ? exq0.pop_front() : exq1.pop_front();
            chk($sformatf("sample_value[%0d]", i), int'(sout[i]), int'(e.val));
            chk($sformatf("strobe_cycle[%0d]", i), cyc, e.due);
          end
        end
      end
      pcs[i]   = cs_n[i];
      psclk[i] = sclk[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int i, input int n, input int budget);
    int b = 0;
    while (nstrobes(i) < n && b < budget) begin
      tick();
      b++;
    end
    if (nstrobes(i) < n) chk($sformatf("strobe_timeout[%0d]", i), nstrobes(i), n);
  endtask

  task automatic chk_idle(input string tag, input int i);
    chk({tag, "_cs_n"},  int'(cs_n[i]),  1);
    chk({tag, "_sclk"},  int'(sclk[i]),  0);
    chk({tag, "_valid"}, int'(valid[i]), 0);
    chk({tag, "_busy"},  int'(busy[i]),  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, v;
    rst = 1'b1;
    en   = '{1'b0, 1'b0};
    miso = '{1'b0, 1'b0};
    fw0  = '{16'h0A5C, 16'h3800, 16'hCFFF, 16'h5000};
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk_idle($sformatf("reset[%0d]", i), i);
      chk($sformatf("reset_sample[%0d]", i), int'(sout[i]), 0);
    end
    rst = 1'b0;
    tick();
    chk_idle("post_reset", 0);

    // Free-running frames: fixed values first, then random words.
    en[0] = 1'b1;
    t = cyc;
    wait_strobes(0, 1, 400);
    chk("latency0", vtime(0, 0) - t, 137);
    wait_strobes(0, 7, 1200);
    for (int k = 1; k < 7; k++) chk("period0", vtime(0, k) - vtime(0, k - 1), 137);

    // Drop enable 50 cycles into a frame: it must still finish and deliver.
    v = vtime(0, 6);
    while (cyc < v + 50) tick();
    en[0] = 1'b0;
    wait_strobes(0, 8, 300);
    chk("period_after_drop", vtime(0, 7) - vtime(0, 6), 137);
    repeat (20) tick();
    chk("no_restart_strobes", nstrobes(0), 8);
    chk_idle("stopped", 0);

    // Reset 70 cycles into a frame: frame aborted, no strobe, sample cleared.
    en[0] = 1'b1;
    t = cyc;
    while (cyc < t + 70) tick();
    chk("mid_frame_cs_low", int'(cs_n[0]), 0);
    rst   = 1'b1;
    en[0] = 1'b0;
    tick();
    rst = 1'b0;
    chk_idle("abort", 0);
    chk("abort_sample", int'(sout[0]), 0);
    repeat (300) tick();
    chk("abort_no_strobe", nstrobes(0), 8);

    // Minimal configuration: clk_div=1, frame_bits=12.
    en[1] = 1'b1;
    t = cyc;
    wait_strobes(1, 1, 100);
    chk("latency1", vtime(1, 0) - t, 27);
    wait_strobes(1, 6, 300);
    for (int k = 1; k < 6; k++) chk("period1", vtime(1, k) - vtime(1, k - 1), 27);
    en[1] = 1'b0;
    repeat (40) tick();
    chk_idle("stopped1", 1);
    chk("pending_exp0", exq0.size(), 0);
    chk("pending_exp1", exq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
